// File: rtl/turn_request_queue.sv
// turn_request_queue
//   Qualifies proximity-sensor turn flags into relative turns (left/right),
//   queues them, and applies at most one queued turn per snake move to the
//   absolute heading used by the snake datapath.
//   Heading encoding: 00=X+, 01=Y+, 10=X-, 11=Y-.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high; clears all state
//   sample         1-cycle strobe: esq/dir hold a new measurement
//   esq, dir       left / right proximity flags (levels)
//   commit         move-boundary strobe: pop one turn and apply it
//   load           load start_dir, flush the queue, sampler back to IDLE
//   start_dir      heading loaded by load
//   direction      current absolute heading (registered)
//   turn_pending   queue not empty (registered)
//   queue_count    entries in queue, 0..DEPTH (registered)
//   turn_left_evt  pulse: left turn qualified and pushed
//   turn_right_evt pulse: right turn qualified and pushed
//   dropped        pulse: turn qualified while queue full, discarded
//   db_estado      sampler FSM state (00 IDLE, 01 QUAL, 10 HELD)
module turn_request_queue #(
  parameter int STABLE_COUNT = 3,
  parameter int DEPTH        = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample,
  input  logic       esq,
  input  logic       dir,
  input  logic       commit,
  input  logic       load,
  input  logic [1:0] start_dir,
  output logic [1:0] direction,
  output logic       turn_pending,
  output logic [2:0] queue_count,
  output logic       turn_left_evt,
  output logic       turn_right_evt,
  output logic       dropped,
  output logic [1:0] db_estado
);

  localparam int         PW         = (DEPTH > 2) ? 2 : 1;
  localparam logic [3:0] STABLE_CNT = 4'(STABLE_COUNT);
  localparam logic [2:0] DEPTH_CNT  = 3'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_QUAL = 2'b01;
  localparam logic [1:0] S_HELD = 2'b10;

  // Relative turn applied to the heading: right = +1, left = -1, 2-bit wrap.
  function automatic logic [1:0] apply_turn(input logic [1:0] head, input logic right);
    return right ? head + 2'd1 : head - 2'd1;
  endfunction

  logic [1:0]    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          cand, cand_nxt;     // candidate class: 0 = left, 1 = right
  logic          qualify;
  logic          cls_turn, cls_right;

  logic          q_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [2:0]    count_nxt;
  logic          pop_en, push_ok, drop;

  // Exactly one flag set is a turn; both or neither is neutral.
  assign cls_turn  = esq ^ dir;
  assign cls_right = dir;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    qualify   = 1'b0;
    if (sample) begin
      case (state)
        S_IDLE: begin
          if (cls_turn) begin
            cand_nxt = cls_right;
            cnt_nxt  = 4'd1;
            if (STABLE_CNT == 4'd1) begin
              qualify   = 1'b1;
              state_nxt = S_HELD;
            end else begin
              state_nxt = S_QUAL;
            end
          end
        end
        S_QUAL: begin
          if (!cls_turn) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
          end else if (cls_right == cand) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == STABLE_CNT) begin
              qualify   = 1'b1;
              state_nxt = S_HELD;
            end
          end else begin
            // Opposite turn restarts the run with the new candidate.
            cand_nxt = cls_right;
            cnt_nxt  = 4'd1;
          end
        end
        S_HELD: begin
          // Holding a turn never repeats it; only neutral re-arms.
          if (!cls_turn) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Pop sees the pre-push contents; a pop on a full queue frees the slot
  // for a simultaneous push. load overrides both.
  assign pop_en  = commit & ~load & (queue_count != 3'd0);
  assign push_ok = qualify & ~load & ((queue_count != DEPTH_CNT) | pop_en);
  assign drop    = qualify & ~load & (queue_count == DEPTH_CNT) & ~pop_en;

  always_comb begin
    count_nxt = queue_count + {2'b00, push_ok} - {2'b00, pop_en};
    if (load) count_nxt = 3'd0;
  end

  always_ff @(posedge clock) begin
    if (push_ok) q_mem[wr_ptr] <= cls_right;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      cand           <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      queue_count    <= 3'd0;
      turn_pending   <= 1'b0;
      direction      <= 2'b00;
      turn_left_evt  <= 1'b0;
      turn_right_evt <= 1'b0;
      dropped        <= 1'b0;
    end else begin
      turn_left_evt  <= push_ok & ~cls_right;
      turn_right_evt <= push_ok & cls_right;
      dropped        <= drop;
      queue_count    <= count_nxt;
      turn_pending   <= (count_nxt != 3'd0);
      if (load) begin
        direction <= start_dir;
        state     <= S_IDLE;
        cnt       <= 4'd0;
        cand      <= 1'b0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        cand  <= cand_nxt;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_en) begin
          rd_ptr    <= rd_ptr + 1'b1;
          direction <= apply_turn(direction, q_mem[rd_ptr]);
        end
      end
    end
  end

  assign db_estado = state;

endmodule
